// File: rtl/hashtable_pkg.sv
// Shared constants and types for the string-matcher hashtable bitmap.
package hashtable_pkg;

  localparam logic [63:0] HT_ANDMSK    = 64'hffdfdfdfdfdfdfdf;
  localparam int unsigned HT_NBITS     = 15;
  localparam int unsigned HT_BM_AWIDTH = HT_NBITS - 3;
  localparam int unsigned HT_RD_LAT    = 2;

  // Multiplicative hash constant shared with the lookup path
  localparam logic [63:0] HASH_MULT = 64'h9e3779b97f4a7c15;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_CLEAR  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HASH  = 3'd1,
    ST_RD    = 3'd2,
    ST_RWAIT = 3'd3,
    ST_MERGE = 3'd4,
    ST_WR    = 3'd5,
    ST_DONE  = 3'd6,
    ST_CLR   = 3'd7
  } state_t;

endpackage

// File: rtl/mul_hash.sv
// Two-stage multiplicative hash: p = top NBITS of (din * HASH_MULT), valid 2 cycles after in_v.
module mul_hash
  import hashtable_pkg::*;
#(
  parameter int unsigned NBITS = HT_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_v,
  input  logic [63:0]      din,
  output logic             out_v,
  output logic [NBITS-1:0] p
);

  logic [63:0] din_q;
  logic        v_q;
  logic [63:0] prod_c;

  assign prod_c = din_q * HASH_MULT;

  // Input register then product register
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= '0;
      v_q   <= 1'b0;
      out_v <= 1'b0;
      p     <= '0;
    end else if (ce) begin
      din_q <= din;
      v_q   <= in_v;
      out_v <= v_q;
      p     <= prod_c[63 -: NBITS];
    end
  end

endmodule

// File: rtl/hashtable_bitmap_writer.sv
// Control-plane writer for the hashtable bitmap: hashed inserts by read-modify-write and clear-all sweep.
module hashtable_bitmap_writer
  import hashtable_pkg::*;
#(
  parameter logic [63:0] ANDMSK    = HT_ANDMSK,
  parameter int unsigned NBITS     = HT_NBITS,
  parameter int unsigned BM_AWIDTH = NBITS - 3,
  parameter int unsigned RD_LAT    = HT_RD_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          in_key,
  input  logic                 in_op,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BM_AWIDTH-1:0] bm_addr,
  output logic                 bm_rd,
  input  logic [7:0]           bm_rdata,
  output logic                 bm_wr,
  output logic [7:0]           bm_wdata,
  output logic                 done_valid,
  output logic [NBITS-1:0]     done_addr,
  output logic                 done_dup,
  output logic [NBITS:0]       occupancy
);

  localparam int unsigned CW = $clog2(RD_LAT + 1);
  localparam logic [NBITS:0] OCC_MAX = {1'b1, {NBITS{1'b0}}};

  state_t               state_q, state_d;
  logic [NBITS-1:0]     haddr_q, haddr_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 dup_q, dup_d;
  logic [CW-1:0]        rw_cnt_q, rw_cnt_d;
  logic [BM_AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                 clr_last_q, clr_last_d;

  logic [BM_AWIDTH-1:0] bm_addr_d;
  logic                 bm_rd_d, bm_wr_d, done_valid_d, done_dup_d;
  logic [7:0]           bm_wdata_d;
  logic [NBITS-1:0]     done_addr_d;
  logic [NBITS:0]       occ_d;

  logic                 accept_c, hv_c, dup_c;
  logic [NBITS-1:0]     hp_c;
  logic [7:0]           wdata_c;

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept_c = in_valid && in_ready;

  // Shared hash, fed with the masked key only on the insert accept cycle
  mul_hash #(.NBITS(NBITS)) u_hash (
    .clk   (clk),
    .rst   (rst),
    .ce    (1'b1),
    .in_v  (accept_c && (in_op == OP_INSERT)),
    .din   (in_key & ANDMSK),
    .out_v (hv_c),
    .p     (hp_c)
  );

  assign dup_c   = rdata_q[haddr_q[2:0]];
  assign wdata_c = rdata_q | (8'h01 << haddr_q[2:0]);

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    rdata_d      = rdata_q;
    dup_d        = dup_q;
    rw_cnt_d     = rw_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    clr_last_d   = clr_last_q;
    bm_addr_d    = bm_addr;
    bm_wdata_d   = bm_wdata;
    bm_rd_d      = 1'b0;
    bm_wr_d      = 1'b0;
    done_valid_d = 1'b0;
    done_addr_d  = done_addr;
    done_dup_d   = done_dup;
    occ_d        = occupancy;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (in_op == OP_CLEAR) begin
            state_d    = ST_CLR;
            clr_cnt_d  = '0;
            clr_last_d = 1'b0;
            bm_addr_d  = '0;
            bm_wr_d    = 1'b1;
            bm_wdata_d = 8'h00;
          end else begin
            state_d = ST_HASH;
          end
        end
      end
      ST_HASH: begin
        if (hv_c) begin
          haddr_d   = hp_c;
          state_d   = ST_RD;
          bm_rd_d   = 1'b1;
          bm_addr_d = hp_c[NBITS-1:3];
          rw_cnt_d  = '0;
        end
      end
      ST_RD: state_d = ST_RWAIT;
      ST_RWAIT: begin
        if (rw_cnt_q == CW'(RD_LAT - 1)) begin
          rdata_d = bm_rdata;
          state_d = ST_MERGE;
        end else begin
          rw_cnt_d = rw_cnt_q + CW'(1);
        end
      end
      ST_MERGE: begin
        dup_d = dup_c;
        if (dup_c) begin
          state_d      = ST_DONE;
          done_valid_d = 1'b1;
          done_addr_d  = haddr_q;
          done_dup_d   = 1'b1;
        end else begin
          state_d    = ST_WR;
          bm_wr_d    = 1'b1;
          bm_wdata_d = wdata_c;
        end
      end
      ST_WR: begin
        state_d      = ST_DONE;
        done_valid_d = 1'b1;
        done_addr_d  = haddr_q;
        done_dup_d   = 1'b0;
        occ_d        = (occupancy == OCC_MAX) ? occupancy : occupancy + (NBITS + 1)'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      ST_CLR: begin
        if (clr_last_q) begin
          state_d      = ST_DONE;
          occ_d        = '0;
          done_valid_d = 1'b1;
          done_addr_d  = '0;
          done_dup_d   = 1'b0;
        end else begin
          clr_cnt_d  = clr_cnt_q + BM_AWIDTH'(1);
          clr_last_d = &clr_cnt_d;
          bm_addr_d  = clr_cnt_d;
          bm_wr_d    = 1'b1;
          bm_wdata_d = 8'h00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      rdata_q    <= '0;
      dup_q      <= 1'b0;
      rw_cnt_q   <= '0;
      clr_cnt_q  <= '0;
      clr_last_q <= 1'b0;
      bm_addr    <= '0;
      bm_rd      <= 1'b0;
      bm_wr      <= 1'b0;
      bm_wdata   <= '0;
      done_valid <= 1'b0;
      done_addr  <= '0;
      done_dup   <= 1'b0;
      occupancy  <= '0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      rdata_q    <= rdata_d;
      dup_q      <= dup_d;
      rw_cnt_q   <= rw_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_last_q <= clr_last_d;
      bm_addr    <= bm_addr_d;
      bm_rd      <= bm_rd_d;
      bm_wr      <= bm_wr_d;
      bm_wdata   <= bm_wdata_d;
      done_valid <= done_valid_d;
      done_addr  <= done_addr_d;
      done_dup   <= done_dup_d;
      occupancy  <= occ_d;
    end
  end

endmodule

// File: tb/tb_hashtable_bitmap_writer.sv
// Bench for hashtable_bitmap_writer: behavioural RAM (read latency 2) plus a reference bitmap model.
module tb_hashtable_bitmap_writer;

  localparam int NW = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_key = '0;
  logic        in_op = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] bm_addr;
  logic        bm_rd;
  logic [7:0]  bm_rdata = 8'hA5;
  logic        bm_wr;
  logic [7:0]  bm_wdata;
  logic        done_valid;
  logic [14:0] done_addr;
  logic        done_dup;
  logic [15:0] occupancy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;

  int unsigned wa_q[$], wd_q[$], wc_q[$];
  int unsigned da_q[$], dd_q[$], do_q[$], dc_q[$];

  logic [7:0] mem [NW];
  logic       mem_clr = 1'b1;
  logic       rv1 = 1'b0;
  logic [7:0] rd1 = 8'h00;

  logic [7:0] exp_mem [NW];
  int         exp_occ = 0;

  always #5 clk = ~clk;

  hashtable_bitmap_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_key     (in_key),
    .in_op      (in_op),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bm_addr    (bm_addr),
    .bm_rd      (bm_rd),
    .bm_rdata   (bm_rdata),
    .bm_wr      (bm_wr),
    .bm_wdata   (bm_wdata),
    .done_valid (done_valid),
    .done_addr  (done_addr),
    .done_dup   (done_dup),
    .occupancy  (occupancy)
  );

  // Behavioural bitmap RAM: write on bm_wr, read data two cycles after bm_rd, junk otherwise
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < NW; i++) mem[i] <= 8'h00;
    end else if (bm_wr) begin
      mem[bm_addr] <= bm_wdata;
    end
    rv1      <= bm_rd;
    rd1      <= mem[bm_addr];
    bm_rdata <= rv1 ? rd1 : 8'hA5;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event recorder, sampled 1 time unit after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (bm_rd) rd_cnt++;
    if (bm_wr) begin
      wa_q.push_back(32'(bm_addr));
      wd_q.push_back(32'(bm_wdata));
      wc_q.push_back(32'(cyc));
    end
    if (done_valid) begin
      da_q.push_back(32'(done_addr));
      dd_q.push_back(32'(done_dup));
      do_q.push_back(32'(occupancy));
      dc_q.push_back(32'(cyc));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference hash: masked key times golden multiplier, top 15 bits
  function automatic logic [14:0] mh(input logic [63:0] k);
    logic [63:0] m;
    m = (k & 64'hffdfdfdfdfdfdfdf) * 64'h9e3779b97f4a7c15;
    return m[63:49];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_insert(input logic [63:0] k, input string tag);
    logic [14:0] h;
    int          w, b, dn0, wr0, rd0, t0;
    logic        exp_dup;
    logic [7:0]  exp_w;
    h       = mh(k);
    w       = int'(h[14:3]);
    b       = int'(h[2:0]);
    exp_dup = exp_mem[w][b];
    exp_w   = exp_mem[w] | (8'h01 << b);
    wait_ready(tag);
    dn0 = da_q.size(); wr0 = wa_q.size(); rd0 = rd_cnt;
    in_key = k; in_op = 1'b0; in_valid = 1'b1; t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && da_q.size() == dn0; i++) @(negedge clk);
    check({tag, "_done_seen"}, 64'(da_q.size()), 64'(dn0 + 1));
    if (!exp_dup) exp_occ++;
    exp_mem[w] = exp_w;
    if (da_q.size() > dn0) begin
      check({tag, "_done_addr"}, 64'(da_q[dn0]), 64'(h));
      check({tag, "_done_dup"}, 64'(dd_q[dn0]), 64'(exp_dup));
      check({tag, "_occupancy"}, 64'(do_q[dn0]), 64'(exp_occ));
      check({tag, "_latency"}, 64'(dc_q[dn0] - t0), exp_dup ? 64'd7 : 64'd8);
    end
    check({tag, "_reads"}, 64'(rd_cnt - rd0), 64'd1);
    check({tag, "_writes"}, 64'(wa_q.size() - wr0), exp_dup ? 64'd0 : 64'd1);
    if (!exp_dup && wa_q.size() > wr0) begin
      check({tag, "_wr_addr"}, 64'(wa_q[wr0]), 64'(w));
      check({tag, "_wr_data"}, 64'(wd_q[wr0]), 64'(exp_w));
    end
    check({tag, "_mem"}, 64'(mem[w]), 64'(exp_w));
  endtask

  initial begin
    logic [63:0] k, ka, kb, kr;
    logic [14:0] ha, hb;
    logic [63:0] ks [3];
    logic        found;
    int          dn0, wr0, rd0, ready_hi, bad, idx, t0, wr_w;

    for (int i = 0; i < NW; i++) exp_mem[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_strobes", 64'({in_ready, bm_rd, bm_wr, done_valid, done_dup}), 64'd0);
    check("rst_data", 64'({bm_addr, bm_wdata, done_addr}), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // First insert and duplicate of the same key
    k = {$urandom, $urandom};
    do_insert(k, "ins_first");
    do_insert(k, "ins_again");

    // Case fold: bit 5 of byte 3 is masked off before hashing
    do_insert(k ^ (64'h20 << 24), "ins_casefold");

    // Clear-all sweep
    wait_ready("clr");
    dn0 = da_q.size(); wr0 = wa_q.size(); rd0 = rd_cnt;
    in_op = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_op = 1'b0;
    ready_hi = 0;
    for (int i = 0; i < 5000 && da_q.size() == dn0; i++) begin
      if (in_ready) ready_hi++;
      @(negedge clk);
    end
    check("clr_done_seen", 64'(da_q.size()), 64'(dn0 + 1));
    check("clr_writes", 64'(wa_q.size() - wr0), 64'd4096);
    bad = 0;
    if (wa_q.size() >= wr0 + NW) begin
      for (int i = 0; i < NW; i++)
        if (wa_q[wr0+i] != i || wd_q[wr0+i] != 0 || wc_q[wr0+i] != wc_q[wr0] + i) bad++;
    end
    check("clr_sweep_bad", 64'(bad), 64'd0);
    check("clr_reads", 64'(rd_cnt - rd0), 64'd0);
    check("clr_ready_low", 64'(ready_hi), 64'd0);
    if (da_q.size() > dn0) begin
      check("clr_done_fields", 64'({da_q[dn0], dd_q[dn0]}), 64'd0);
      check("clr_occupancy", 64'(do_q[dn0]), 64'd0);
    end
    for (int i = 0; i < NW; i++) exp_mem[i] = 8'h00;
    exp_occ = 0;

    // Two keys sharing a bitmap word on different bits
    found = 1'b0;
    ka = {$urandom, $urandom};
    kb = '0;
    ha = mh(ka);
    for (int i = 0; i < 100000 && !found; i++) begin
      kb = {$urandom, $urandom};
      hb = mh(kb);
      if (hb[14:3] == ha[14:3] && hb[2:0] != ha[2:0]) found = 1'b1;
    end
    check("pair_found", 64'(found), 64'd1);
    hb = mh(kb);
    do_insert(ka, "pair_a");
    wr_w = wa_q.size();
    do_insert(kb, "pair_b");
    if (found && wa_q.size() > wr_w) begin
      check("pair_wdata", 64'(wd_q[wr_w]), 64'((8'h01 << ha[2:0]) | (8'h01 << hb[2:0])));
      check("pair_occupancy", 64'(occupancy), 64'd2);
    end

    // Three keys queued with in_valid held high
    for (int i = 0; i < 3; i++) ks[i] = {$urandom, $urandom};
    wait_ready("queue");
    dn0 = da_q.size();
    idx = 0; in_op = 1'b0; in_valid = 1'b1; in_key = ks[0];
    for (int c = 0; c < 300 && idx < 3; c++) begin
      if (in_ready) begin
        idx++;
        @(negedge clk);
        if (idx < 3) in_key = ks[idx];
        else in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 60 && da_q.size() < dn0 + 3; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("queue_accepts", 64'(idx), 64'd3);
    check("queue_done_count", 64'(da_q.size() - dn0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      logic [14:0] h;
      logic        d;
      h = mh(ks[i]);
      d = exp_mem[h[14:3]][h[2:0]];
      exp_mem[h[14:3]] = exp_mem[h[14:3]] | (8'h01 << h[2:0]);
      if (!d) exp_occ++;
      if (da_q.size() > dn0 + i) begin
        check($sformatf("queue%0d_addr", i), 64'(da_q[dn0+i]), 64'(h));
        check($sformatf("queue%0d_dup", i), 64'(dd_q[dn0+i]), 64'(d));
        check($sformatf("queue%0d_occ", i), 64'(do_q[dn0+i]), 64'(exp_occ));
      end
    end

    // Reset pulsed while waiting for read data
    kr = '0;
    for (int i = 0; i < 1000; i++) begin
      logic [14:0] h;
      kr = {$urandom, $urandom};
      h = mh(kr);
      if (!exp_mem[h[14:3]][h[2:0]]) break;
    end
    wait_ready("rstmid");
    rd0 = rd_cnt;
    in_key = kr; in_op = 1'b0; in_valid = 1'b1; t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_read_issued", 64'(rd_cnt - rd0), 64'd1);
    dn0 = da_q.size(); wr0 = wa_q.size(); rd0 = rd_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ready_in_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_after", 64'(in_ready), 64'd1);
    check("rstmid_occupancy", 64'(occupancy), 64'd0);
    repeat (20) @(negedge clk);
    check("rstmid_no_write", 64'(wa_q.size() - wr0), 64'd0);
    check("rstmid_no_done", 64'(da_q.size() - dn0), 64'd0);
    check("rstmid_no_read", 64'(rd_cnt - rd0), 64'd0);
    ha = mh(kr);
    check("rstmid_mem", 64'(mem[ha[14:3]]), 64'(exp_mem[ha[14:3]]));
    exp_occ = 0;
    do_insert(kr, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
